seq_divider: RTL and testbench

- Parametrised iterative restoring divider for the ALU datapath. It is the successor to the fixed 32-bit DIVU unit.
- Computes quotient and remainder at one bit per clock, with an explicit start/busy/done handshake and optional signed mode.
- Result is also exposed packed as {remainder, quotient}, the HI/LO format consumed by the MFHI/MFLO path.

---
 rtl/div_pkg.sv | 13 +
 rtl/div_step.sv | 29 ++
 rtl/seq_divider.sv | 116 +++++++++++
 tb/tb_seq_divider.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider.
// Holds the FSM state encoding, the default width and the counter-width helper.
package div_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} div_state_t;

  localparam int DIV_W_DEFAULT = 32;

  function automatic int div_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract the divisor.
// Purely combinational; instantiated once and reused every RUN cycle.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dvsr,
  output logic [WIDTH-1:0] rem_nxt,
  output logic [WIDTH-1:0] quo_nxt
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // rem < dvsr <= 2^WIDTH keeps the result in range, so bit WIDTH is a reliable sign.
  assign shifted = {rem, quo[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvsr};

  always_comb begin
    rem_nxt = shifted[WIDTH-1:0];
    quo_nxt = {quo[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      rem_nxt = trial[WIDTH-1:0];
      quo_nxt = {quo[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider, one quotient bit per clock, start/busy/done handshake.
// Signed (DIV) mode is built only when SEQ_DIVIDER_SIGNED_EN is defined; otherwise all divides are DIVU.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 busy,
  output logic                 done,
  output logic                 div_by_zero,
  output logic [WIDTH-1:0]     quotient,
  output logic [WIDTH-1:0]     remainder,
  output logic [2*WIDTH-1:0]   result
);

  localparam int CW = div_cnt_w(WIDTH);

`ifdef SEQ_DIVIDER_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  div_state_t       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem, quo, dmag;
  logic             neg_q, neg_r;

  logic             op_sgn, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] rem_nxt, quo_nxt;

  // With signed mode compiled out these fold to constants and the negators vanish.
  assign op_sgn = SIGNED_EN & is_signed;
  assign a_neg  = op_sgn & dividend[WIDTH-1];
  assign b_neg  = op_sgn & divisor[WIDTH-1];
  assign a_mag  = a_neg ? -dividend : dividend;
  assign b_mag  = b_neg ? -divisor  : divisor;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem),
    .quo     (quo),
    .dvsr    (dmag),
    .rem_nxt (rem_nxt),
    .quo_nxt (quo_nxt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      cnt         <= '0;
      rem         <= '0;
      quo         <= '0;
      dmag        <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state       <= DONE;
            end else begin
              rem   <= '0;
              quo   <= a_mag;
              dmag  <= b_mag;
              neg_q <= a_neg ^ b_neg;
              neg_r <= a_neg;
              cnt   <= CW'(WIDTH);
              busy  <= 1'b1;
              state <= RUN;
            end
          end
        end
        RUN: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= FIX;
        end
        FIX: begin
          // Quotient sign follows the operand signs; remainder follows the dividend.
          quotient    <= neg_q ? -quo : quo;
          remainder   <= neg_r ? -rem : rem;
          div_by_zero <= 1'b0;
          busy        <= 1'b0;
          done        <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign result = {remainder, quotient};

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider at WIDTH=32 and WIDTH=8; expectations adapt to SEQ_DIVIDER_SIGNED_EN.
module tb_seq_divider;

`ifdef SEQ_DIVIDER_SIGNED_EN
  localparam bit SG = 1'b1;
`else
  localparam bit SG = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        start32, sgn32;
  logic [31:0] a32, b32, q32, r32;
  logic [63:0] res32;
  logic        busy32, done32, dz32;

  logic        start8, sgn8;
  logic [7:0]  a8, b8, q8, r8;
  logic [15:0] res8;
  logic        busy8, done8, dz8;

  seq_divider #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .is_signed(sgn32),
    .dividend(a32), .divisor(b32), .busy(busy32), .done(done32),
    .div_by_zero(dz32), .quotient(q32), .remainder(r32), .result(res32)
  );

  seq_divider #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .is_signed(sgn8),
    .dividend(a8), .divisor(b8), .busy(busy8), .done(done8),
    .div_by_zero(dz8), .quotient(q8), .remainder(r8), .result(res8)
  );

  logic        sel8;
  logic        busy_m, done_m, dz_m;
  logic [31:0] q_m, r_m;
  logic [63:0] res_m;
  assign busy_m = sel8 ? busy8 : busy32;
  assign done_m = sel8 ? done8 : done32;
  assign dz_m   = sel8 ? dz8   : dz32;
  assign q_m    = sel8 ? {24'b0, q8} : q32;
  assign r_m    = sel8 ? {24'b0, r8} : r32;
  assign res_m  = sel8 ? {48'b0, res8} : res32;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives a one-cycle start and returns #1 into cycle 1.
  task automatic start_op(input bit w8, input bit sgn, input logic [31:0] a, input logic [31:0] b);
    sel8 = w8;
    if (w8) begin
      start8 = 1'b1; sgn8 = sgn; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      start32 = 1'b1; sgn32 = sgn; a32 = a; b32 = b;
    end
    tick();
    start8  = 1'b0;
    start32 = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!done_m && cyc < 60) begin
      tick();
      cyc++;
    end
  endtask

  task automatic do_div(input string tag, input bit w8, input bit sgn,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] q, input logic [31:0] r,
                        input bit dz, input int lat);
    int cyc;
    logic [63:0] exp_res;
    exp_res = w8 ? {48'b0, r[7:0], q[7:0]} : {r, q};
    start_op(w8, sgn, a, b);
    if (lat > 1) chk({tag, ".busy"}, 64'(busy_m), 64'(1));
    wait_done(cyc);
    chk({tag, ".lat"}, 64'(cyc), 64'(lat));
    chk({tag, ".q"}, 64'(q_m), w8 ? 64'(q[7:0]) : 64'(q));
    chk({tag, ".r"}, 64'(r_m), w8 ? 64'(r[7:0]) : 64'(r));
    chk({tag, ".dz"}, 64'(dz_m), 64'(dz));
    chk({tag, ".res"}, res_m, exp_res);
    tick();
    chk({tag, ".pulse"}, 64'(done_m), 64'(0));
  endtask

  task automatic reset_mid(input string tag, input bit w8, input int at_cyc);
    int pulses;
    start_op(w8, 1'b0, 32'hDEAD_BEEF, 32'h0000_0003);
    repeat (at_cyc - 1) tick();
    reset = 1'b1;
    tick();
    chk({tag, ".busy"}, 64'(busy_m), 64'(0));
    chk({tag, ".done"}, 64'(done_m), 64'(0));
    chk({tag, ".q"}, 64'(q_m), 64'(0));
    chk({tag, ".r"}, 64'(r_m), 64'(0));
    chk({tag, ".dz"}, 64'(dz_m), 64'(0));
    reset = 1'b0;
    pulses = 0;
    repeat (45) begin
      tick();
      if (done_m) pulses++;
    end
    chk({tag, ".nodone"}, 64'(pulses), 64'(0));
  endtask

  task automatic handshake(input string tag, input bit w8, input int lat);
    int pulses, dcyc, cyc;
    start_op(w8, 1'b0, 32'd100, 32'd7);
    repeat (4) tick();
    sel8 = w8;
    if (w8) begin
      start8 = 1'b1; a8 = 8'd250; b8 = 8'd3;
    end else begin
      start32 = 1'b1; a32 = 32'd1000; b32 = 32'd3;
    end
    tick();
    start8  = 1'b0;
    start32 = 1'b0;
    pulses = 0;
    dcyc   = 0;
    for (cyc = 6; cyc < lat + 10; cyc++) begin
      if (done_m) begin
        pulses++;
        dcyc = cyc;
      end
      tick();
    end
    chk({tag, ".pulses"}, 64'(pulses), 64'(1));
    chk({tag, ".lat"}, 64'(dcyc), 64'(lat));
    chk({tag, ".q"}, 64'(q_m), 64'(14));
    chk({tag, ".r"}, 64'(r_m), 64'(2));
  endtask

  initial begin
    sel8 = 1'b0;
    start32 = 1'b0; sgn32 = 1'b0; a32 = '0; b32 = '0;
    start8  = 1'b0; sgn8  = 1'b0; a8  = '0; b8  = '0;
    reset = 1'b1;
    repeat (3) tick();
    chk("rst.busy", 64'(busy32), 64'(0));
    chk("rst.done", 64'(done32), 64'(0));
    chk("rst.dz",   64'(dz32),   64'(0));
    chk("rst.res",  res32,       64'(0));
    chk("rst8.res", 64'(res8),   64'(0));
    reset = 1'b0;
    tick();

    // WIDTH = 32
    do_div("u100_7",   1'b0, 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34);
    do_div("s-100_7",  1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7,
           SG ? 32'hFFFF_FFF2 : 32'h2492_4916, SG ? 32'hFFFF_FFFE : 32'd2, 1'b0, 34);
    do_div("s100_-7",  1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9,
           SG ? 32'hFFFF_FFF2 : 32'd0, SG ? 32'd2 : 32'd100, 1'b0, 34);
    do_div("dz",       1'b0, 1'b0, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1, 1);
    do_div("smin_-1",  1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
           SG ? 32'h8000_0000 : 32'd0, SG ? 32'd0 : 32'h8000_0000, 1'b0, 34);
    do_div("umax_1",   1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 34);
    handshake("hs32", 1'b0, 34);
    reset_mid("rst32", 1'b0, 10);

    // WIDTH = 8
    do_div("u200_13",  1'b1, 1'b0, 32'd200, 32'd13, 32'd15, 32'd5, 1'b0, 10);
    do_div("s8-100_7", 1'b1, 1'b1, 32'h9C, 32'd7,
           SG ? 32'hF2 : 32'h16, SG ? 32'hFE : 32'h02, 1'b0, 10);
    do_div("s8100_-7", 1'b1, 1'b1, 32'h64, 32'hF9,
           SG ? 32'hF2 : 32'h00, SG ? 32'h02 : 32'h64, 1'b0, 10);
    do_div("dz8",      1'b1, 1'b0, 32'h12, 32'd0, 32'hFF, 32'h12, 1'b1, 1);
    do_div("s8min_-1", 1'b1, 1'b1, 32'h80, 32'hFF,
           SG ? 32'h80 : 32'h00, SG ? 32'h00 : 32'h80, 1'b0, 10);
    do_div("u8max_1",  1'b1, 1'b0, 32'hFF, 32'd1, 32'hFF, 32'd0, 1'b0, 10);
    handshake("hs8", 1'b1, 10);
    reset_mid("rst8", 1'b1, 5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
